// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: host-side 8259A bus controller (init writes, INTA service, EOI)
// Ports: clock/reset (async, active high); start begins init from IDLE.
//   PIC bus: chip_select, read_enable, write_enable, INTA (all active low), A0, data_out, data_in, INT.
//   Consumer: vector/vector_valid/vector_ready handshake; eoi_req + eoi_specific request an EOI write.
//   Status: init_done (sticky until reset), busy (any state but IDLE/READY).
module pic_host_sequencer #(
    parameter logic [7:0] ICW1       = 8'h13,
    parameter logic [7:0] ICW2       = 8'h20,
    parameter logic [7:0] ICW3       = 8'h00,
    parameter logic [7:0] ICW4       = 8'h03,
    parameter logic [7:0] OCW1       = 8'h00,
    parameter int         WR_PULSE   = 2,
    parameter int         INTA_PULSE = 2,
    parameter int         INTA_GAP   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       chip_select,
    output logic       read_enable,
    output logic       write_enable,
    output logic       A0,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic       INT,
    output logic       INTA,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    input  logic       eoi_req,
    input  logic       eoi_specific
);
    typedef enum logic [3:0] {IDLE, INIT, READY, ACK1, GAP, ACK2, VEC, WAIT_EOI, EOI} state_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} phase_t;
    localparam logic AEOI = ICW1[0] && ICW4[1];
    state_t     state;
    phase_t     phase;
    logic [2:0] idx;
    logic [7:0] cnt;
    // init word index: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1; 5 means the sequence is finished
    function automatic logic [2:0] next_idx(input logic [2:0] i);
        logic [2:0] n;
        n = i + 3'd1;
        if (n == 3'd2 && ICW1[1]) n = 3'd3;
        if (n == 3'd3 && !ICW1[0]) n = 3'd4;
        return n;
    endfunction
    function automatic logic [7:0] init_word(input logic [2:0] i);
        return i == 3'd0 ? ICW1 : i == 3'd1 ? ICW2 : i == 3'd2 ? ICW3 : i == 3'd3 ? ICW4 : OCW1;
    endfunction
    assign read_enable = 1'b1;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= W_IDLE;
            idx          <= 3'd0;
            cnt          <= 8'd0;
            chip_select  <= 1'b1;
            write_enable <= 1'b1;
            INTA         <= 1'b1;
            A0           <= 1'b0;
            data_out     <= 8'h00;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= INIT;
                    busy  <= 1'b1;
                    idx   <= 3'd0;
                    phase <= W_IDLE;
                end
                // INIT and EOI share the write engine; only INIT launches from W_IDLE,
                // which also guarantees chip_select is high for a cycle between writes
                INIT, EOI: case (phase)
                    W_IDLE: begin
                        chip_select <= 1'b0;
                        A0          <= idx != 3'd0;
                        data_out    <= init_word(idx);
                        phase       <= W_SETUP;
                    end
                    W_SETUP: begin
                        write_enable <= 1'b0;
                        cnt          <= 8'(WR_PULSE - 1);
                        phase        <= W_STROBE;
                    end
                    W_STROBE: if (cnt == 8'd0) begin
                        write_enable <= 1'b1;
                        phase        <= W_HOLD;
                    end else cnt <= cnt - 8'd1;
                    W_HOLD: begin
                        chip_select <= 1'b1;
                        phase       <= W_IDLE;
                        if (state == EOI || next_idx(idx) == 3'd5) begin
                            state     <= READY;
                            busy      <= 1'b0;
                            init_done <= 1'b1;
                        end else idx <= next_idx(idx);
                    end
                endcase
                READY: if (INT) begin
                    INTA  <= 1'b0;
                    cnt   <= 8'(INTA_PULSE - 1);
                    state <= ACK1;
                    busy  <= 1'b1;
                end
                ACK1: if (cnt == 8'd0) begin
                    INTA  <= 1'b1;
                    cnt   <= 8'(INTA_GAP - 1);
                    state <= GAP;
                end else cnt <= cnt - 8'd1;
                GAP: if (cnt == 8'd0) begin
                    INTA  <= 1'b0;
                    cnt   <= 8'(INTA_PULSE - 1);
                    state <= ACK2;
                end else cnt <= cnt - 8'd1;
                ACK2: if (cnt == 8'd0) begin
                    INTA   <= 1'b1;
                    vector <= data_in;
                    state  <= VEC;
                end else cnt <= cnt - 8'd1;
                // first VEC cycle raises valid; the handshake is only honoured once valid is visible
                VEC: if (!vector_valid) vector_valid <= 1'b1;
                else if (vector_ready) begin
                    vector_valid <= 1'b0;
                    state        <= AEOI ? READY : WAIT_EOI;
                    busy         <= !AEOI;
                end
                WAIT_EOI: if (eoi_req) begin
                    chip_select <= 1'b0;
                    A0          <= 1'b0;
                    data_out    <= eoi_specific ? (8'h60 | {5'b0, vector[2:0]}) : 8'h20;
                    phase       <= W_SETUP;
                    state       <= EOI;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb_pic_host_sequencer: scoreboard bench for two sequencer configurations (defaults, and cascade/non-AEOI)
module tb_pic_host_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] start = 2'b0, int_in = 2'b0, rdy = 2'b0, eoi = 2'b0, eoisp = 2'b0;
    logic [1:0] cs, rd, we, a0, inta, done, busy, vv;
    logic [1:0] par = 2'b0;
    logic [7:0] dout[2], din[2], vec[2];
    logic [7:0] pic_vec[2] = '{8'h00, 8'h00};
    int checks = 0, fails = 0;
    logic [31:0] q0[$], q1[$];

    always #5 clock = ~clock;

    pic_host_sequencer dut0 (
        .clock(clock), .reset(reset), .start(start[0]), .chip_select(cs[0]), .read_enable(rd[0]),
        .write_enable(we[0]), .A0(a0[0]), .data_out(dout[0]), .data_in(din[0]), .INT(int_in[0]),
        .INTA(inta[0]), .init_done(done[0]), .busy(busy[0]), .vector(vec[0]), .vector_valid(vv[0]),
        .vector_ready(rdy[0]), .eoi_req(eoi[0]), .eoi_specific(eoisp[0]));

    pic_host_sequencer #(.ICW1(8'h11), .ICW4(8'h01)) dut1 (
        .clock(clock), .reset(reset), .start(start[1]), .chip_select(cs[1]), .read_enable(rd[1]),
        .write_enable(we[1]), .A0(a0[1]), .data_out(dout[1]), .data_in(din[1]), .INT(int_in[1]),
        .INTA(inta[1]), .init_done(done[1]), .busy(busy[1]), .vector(vec[1]), .vector_valid(vv[1]),
        .vector_ready(rdy[1]), .eoi_req(eoi[1]), .eoi_specific(eoisp[1]));

    // event words: 1=write {data,cs_len,we_last,we_first,unstable,a0,we_len}, 3=INTA pulse {low,high_before},
    // 5=INTA end to vector_valid latency, 2=vector accepted {vector}
    function automatic logic [31:0] wr(input logic a, input logic [7:0] d);
        return {4'h1, d, 8'd4, 3'b110, a, 8'd2};
    endfunction
    function automatic logic [31:0] pulse(input logic [7:0] hi);
        return {4'h3, 8'd2, hi, 12'h000};
    endfunction

    function automatic void push(input int d, input logic [31:0] e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic got(input int d, input logic [31:0] e);
        logic [31:0] x;
        checks++;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            fails++;
            $display("FAIL unexpected_event dut%0d got %h want none", d, e);
        end else begin
            if (d == 0) x = q0.pop_front();
            else x = q1.pop_front();
            if (x !== e) begin
                fails++;
                $display("FAIL event_type%0h dut%0d got %h want %h", e[31:28], d, e, x);
            end
        end
    endtask

    task automatic chk(input string n, input int g, input int e);
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s got %0h want %0h", n, g, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic cond(input int d, input int k);
        return k == 0 ? done[d] : k == 1 ? vv[d] : k == 2 ? !inta[d] : k == 3 ? inta[d] :
               k == 4 ? (a0[d] && !we[d] && !done[d]) : !busy[d];
    endfunction

    task automatic wait_for(input string n, input int d, input int k, input int maxc);
        checks++;
        for (int i = 0; i < maxc && !cond(d, k); i++) tick(1);
        if (!cond(d, k)) begin
            fails++;
            $display("FAIL %s dut%0d got timeout after %0d cycles want event", n, d, maxc);
        end
    endtask

    task automatic exp_init(input int d);
        if (d == 0) begin
            push(0, wr(1'b0, 8'h13)); push(0, wr(1'b1, 8'h20));
            push(0, wr(1'b1, 8'h03)); push(0, wr(1'b1, 8'h00));
        end else begin
            push(1, wr(1'b0, 8'h11)); push(1, wr(1'b1, 8'h20)); push(1, wr(1'b1, 8'h00));
            push(1, wr(1'b1, 8'h01)); push(1, wr(1'b1, 8'h00));
        end
    endtask

    task automatic exp_ack(input int d, input logic [7:0] v);
        push(d, pulse(8'd15));
        push(d, pulse(8'd2));
        push(d, {4'h5, 8'd1, 20'h0});
        push(d, {4'h2, v, 20'h0});
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1; tick(1); start[d] = 1'b0;
    endtask
    task automatic accept(input int d);
        rdy[d] = 1'b1; tick(1); rdy[d] = 1'b0;
    endtask
    task automatic send_eoi(input int d, input logic sp);
        eoisp[d] = sp; eoi[d] = 1'b1; tick(1); eoi[d] = 1'b0;
    endtask

    // PIC data model: vector appears on the bus only during the second INTA pulse
    for (genvar g = 0; g < 2; g++) begin : pic
        always @(negedge inta[g] or posedge reset) par[g] <= reset ? 1'b0 : ~par[g];
        assign din[g] = (!inta[g] && !par[g]) ? pic_vec[g] : 8'hFF;
    end

    for (genvar g = 0; g < 2; g++) begin : mon
        logic pcs = 1'b1, pinta = 1'b1, pvv = 1'b0, pwe = 1'b1, we_first = 1'b1, unstable = 1'b0, wa0 = 1'b0;
        logic [7:0] cs_len = 0, we_len = 0, low_len = 0, hi_len = 8'd15, hi_before = 0, since = 8'hFF;
        logic [7:0] wdata = 0, held = 0;
        always @(negedge clock) begin
            if (reset) begin
                pcs = 1'b1; pinta = 1'b1; pvv = 1'b0;
                cs_len = 0; we_len = 0; low_len = 0; hi_len = 8'd15; since = 8'hFF;
            end else begin
                if (!cs[g]) begin
                    if (pcs) begin
                        cs_len = 0; we_len = 0; wa0 = a0[g]; wdata = dout[g]; we_first = we[g]; unstable = 1'b0;
                    end
                    cs_len++;
                    if (!we[g]) we_len++;
                    if (a0[g] !== wa0 || dout[g] !== wdata) unstable = 1'b1;
                    pwe = we[g];
                end else if (!pcs) got(g, {4'h1, wdata, cs_len, pwe, we_first, unstable, wa0, we_len});
                pcs = cs[g];
                if (!inta[g]) begin
                    if (pinta) begin
                        hi_before = hi_len; low_len = 0;
                    end
                    low_len++;
                end else begin
                    if (!pinta) begin
                        got(g, {4'h3, low_len, hi_before, 12'h000});
                        hi_len = 0; since = 0;
                    end else if (since != 8'hFF) since++;
                    if (hi_len < 8'd15) hi_len++;
                end
                pinta = inta[g];
                if (vv[g] && !pvv) begin
                    got(g, {4'h5, since, 20'h0});
                    held = vec[g];
                end
                if (vv[g]) begin
                    checks++;
                    if (vec[g] !== held) begin
                        fails++;
                        $display("FAIL vector_stable dut%0d got %h want %h", g, vec[g], held);
                    end
                end
                if (vv[g] && rdy[g]) got(g, {4'h2, vec[g], 20'h0});
                pvv = vv[g];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        chk("rst_cs", int'(cs[0]), 1); chk("rst_rd", int'(rd[0]), 1); chk("rst_we", int'(we[0]), 1);
        chk("rst_inta", int'(inta[0]), 1); chk("rst_a0", int'(a0[0]), 0); chk("rst_dout", int'(dout[0]), 0);
        chk("rst_done", int'(done[0]), 0); chk("rst_busy", int'(busy[0]), 0);
        chk("rst_vec", int'(vec[0]), 0); chk("rst_vv", int'(vv[0]), 0);
        reset = 1'b0;
        tick(2);
        // defaults: ICW1, ICW2, ICW4, OCW1 (no ICW3)
        exp_init(0);
        pulse_start(0);
        chk("busy_init", int'(busy[0]), 1);
        chk("done_early", int'(done[0]), 0);
        wait_for("init_done0", 0, 0, 100);
        tick(1);
        chk("init0_all_writes", q0.size(), 0);
        chk("ready_idle_busy", int'(busy[0]), 0);
        pulse_start(0);
        tick(10);
        // cascade config writes ICW3 too
        exp_init(1);
        pulse_start(1);
        wait_for("init_done1", 1, 0, 100);
        tick(1);
        chk("init1_all_writes", q1.size(), 0);
        // AEOI interrupt: vector 8'h23, no EOI write afterwards
        pic_vec[0] = 8'h23;
        exp_ack(0, 8'h23);
        int_in[0] = 1'b1;
        tick(1);
        chk("inta_latency", int'(inta[0]), 0);
        int_in[0] = 1'b0;
        wait_for("vv0", 0, 1, 20);
        tick(3);
        chk("vv_held", int'(vv[0]), 1);
        accept(0);
        tick(1);
        chk("vv_cleared", int'(vv[0]), 0);
        tick(5);
        chk("aeoi_ready", int'(busy[0]), 0);
        send_eoi(0, 1'b1);
        tick(10);
        chk("aeoi_no_eoi", q0.size(), 0);
        // non-AEOI: specific then non-specific EOI
        pic_vec[1] = 8'h25;
        for (int r = 0; r < 2; r++) begin
            exp_ack(1, 8'h25);
            push(1, wr(1'b0, r == 0 ? 8'h65 : 8'h20));
            int_in[1] = 1'b1;
            tick(1);
            int_in[1] = 1'b0;
            wait_for("vv1", 1, 1, 20);
            accept(1);
            tick(2);
            chk("wait_eoi_busy", int'(busy[1]), 1);
            send_eoi(1, r == 0);
            chk("eoi_cs_latency", int'(cs[1]), 0);
            wait_for("eoi_done", 1, 5, 20);
            tick(20);
        end
        // back-pressure with INT held high
        pic_vec[1] = 8'h26;
        exp_ack(1, 8'h26);
        push(1, wr(1'b0, 8'h66));
        exp_ack(1, 8'h26);
        push(1, wr(1'b0, 8'h20));
        int_in[1] = 1'b1;
        wait_for("vv_bp", 1, 1, 20);
        tick(10);
        chk("bp_vv_held", int'(vv[1]), 1);
        chk("bp_no_inta", int'(inta[1]), 1);
        accept(1);
        tick(2);
        chk("bp_no_inta_before_eoi", int'(inta[1]), 1);
        send_eoi(1, 1'b1);
        wait_for("bp_second_inta", 1, 2, 30);
        int_in[1] = 1'b0;
        wait_for("vv_bp2", 1, 1, 20);
        accept(1);
        tick(2);
        send_eoi(1, 1'b0);
        wait_for("bp_eoi_done", 1, 5, 20);
        tick(5);
        chk("bp_events", q1.size(), 0);
        // reset during the ICW2 strobe
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        push(0, wr(1'b0, 8'h13));
        pulse_start(0);
        wait_for("icw2_strobe", 0, 4, 30);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_cs", int'(cs[0]), 1); chk("rst_mid_we", int'(we[0]), 1);
        chk("rst_mid_done0", int'(done[0]), 0); chk("rst_mid_done1", int'(done[1]), 0);
        chk("rst_mid_busy", int'(busy[0]), 0);
        tick(1);
        reset = 1'b0;
        chk("rst_mid_icw1_only", q0.size(), 0);
        // reset during ACK2
        exp_init(1);
        pulse_start(1);
        wait_for("init_done1b", 1, 0, 100);
        tick(20);
        push(1, pulse(8'd15));
        int_in[1] = 1'b1;
        wait_for("ack1", 1, 2, 10);
        int_in[1] = 1'b0;
        wait_for("gap", 1, 3, 10);
        wait_for("ack2", 1, 2, 10);
        #2 reset = 1'b1;
        #1;
        chk("rst_ack2_inta", int'(inta[1]), 1); chk("rst_ack2_cs", int'(cs[1]), 1);
        chk("rst_ack2_done", int'(done[1]), 0); chk("rst_ack2_vv", int'(vv[1]), 0);
        tick(1);
        reset = 1'b0;
        chk("rst_ack2_events", q1.size(), 0);
        // a fresh start reruns the whole init from ICW1
        exp_init(0);
        pulse_start(0);
        wait_for("init_done0b", 0, 0, 100);
        tick(1);
        chk("rerun_init", q0.size(), 0);
        tick(5);
        chk("final_q1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pic_host_sequencer.md
Name: pic_host_sequencer

Overview:
- Host-side controller for the PIC_8259A: plays the CPU's part on the PIC bus so the rest of the design never toggles PIC strobes directly.
- After start, writes the ICW1..ICW4 sequence and OCW1.
- Then services interrupts: on INT it issues the two-pulse INTA cycle, captures the vector, and hands it to a consumer over valid/ready.
- On consumer request it writes a specific or non-specific EOI.

Parameters:
- ICW1, 8'h13, ICW1 value (bit0 IC4, bit1 SNGL).
- ICW2, 8'h20, vector base.
- ICW3, 8'h00, cascade word; written only when ICW1[1]=0.
- ICW4, 8'h03, mode word; written only when ICW1[0]=1; bit1=AEOI.
- OCW1, 8'h00, initial mask.
- WR_PULSE, 2, cycles write_enable held low (≥1).
- INTA_PULSE, 2, cycles each INTA pulse held low (≥1).
- INTA_GAP, 2, high cycles between the two INTA pulses (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin init; ignored unless in IDLE.
- chip_select  out  1  PIC chip select, active low.
- read_enable  out  1  PIC RD, active low; held 1 (unused).
- write_enable  out  1  PIC WR, active low.
- A0  out  1  PIC address bit.
- data_out  out  8  PIC write data.
- data_in  in  8  PIC data bus read path (vector during second INTA).
- INT  in  1  PIC interrupt output, active high.
- INTA  out  1  PIC acknowledge, active low.
- init_done  out  1  high once init writes complete; stays high until reset.
- busy  out  1  high in any state except IDLE and READY.
- vector  out  8  captured vector.
- vector_valid  out  1  vector handshake valid.
- vector_ready  in  1  consumer accepts the vector.
- eoi_req  in  1  one-cycle pulse: send EOI for the outstanding interrupt.
- eoi_specific  in  1  sampled with eoi_req: 1 = specific EOI, 0 = non-specific.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - chip_select=1, read_enable=1, write_enable=1, INTA=1, A0=0, data_out=0.
  - init_done=0, busy=0, vector=0, vector_valid=0.
  - State IDLE; any partial bus cycle is abandoned with strobes deasserted.
- Write engine: every PIC write is one atomic transaction.
  - SETUP, 1 cycle: chip_select=0, A0 and data_out valid, write_enable=1.
  - STROBE, WR_PULSE cycles: write_enable=0.
  - HOLD, 1 cycle: write_enable=1, chip_select still 0, A0 and data stable.
  - Then chip_select returns to 1. Total length: WR_PULSE+2 cycles.
- States:
  - IDLE: on start go to INIT.
  - INIT: issues writes in order, skipping the optional words:
    - ICW1 with A0=0.
    - ICW2 with A0=1.
    - ICW3 with A0=1, only if ICW1[1]=0.
    - ICW4 with A0=1, only if ICW1[0]=1.
    - OCW1 with A0=1.
    - After the last HOLD, set init_done=1 and go to READY.
  - READY: when INT is sampled 1, go to ACK1.
  - ACK1: INTA=0 for INTA_PULSE cycles.
  - GAP: INTA=1 for INTA_GAP cycles.
  - ACK2: INTA=0 for INTA_PULSE cycles. data_in is registered into vector on the last ACK2 cycle, then INTA=1.
  - VEC: vector_valid=1 with vector stable; on vector_valid&&vector_ready, clear vector_valid.
    - If AEOI is active, return to READY.
    - Otherwise go to WAIT_EOI.
  - WAIT_EOI: on eoi_req, write the EOI with A0=0:
    - specific: data = 8'h60 | vector[2:0];
    - non-specific: data = 8'h20.
    - After HOLD, return to READY.
- AEOI is active iff ICW1[0]=1 && ICW4[1]=1.
- INT timing:
  - INT is not re-evaluated once ACK1 starts; the full INTA cycle always completes even if INT drops.
  - INT is ignored outside READY.
- No new INTA cycle starts while a vector is pending or an EOI is outstanding.
- eoi_req outside WAIT_EOI is ignored. start outside IDLE is ignored.
- vector_ready while vector_valid=0 has no effect.
- Latencies:
  - INT sampled in READY → first INTA low: next cycle.
  - INT sampled → vector_valid: 2*INTA_PULSE+INTA_GAP+1 cycles.
  - eoi_req → chip_select low: next cycle.

Test Plan:
- Init, defaults: reset, then start.
  - Writes are (A0,data) = (0,13), (1,20), (1,03), (1,00); no ICW3 write.
  - Each chip_select low for 4 cycles with write_enable low for 2.
  - init_done rises after the 4th write.
- Init with cascade (ICW1=8'h11): five writes, with ICW3 between ICW2 and ICW4.
- Interrupt service, AEOI: init, then assert IRR[3].
  - INT rises, then INTA pattern 0,0,1,1,0,0.
  - vector=8'h23, vector_valid held until vector_ready=1.
  - Returns to READY with no EOI write.
- Non-AEOI (ICW4=8'h01): after vector 8'h25 is accepted, eoi_req with eoi_specific=1 writes A0=0, data=8'h65.
  - A repeat run with eoi_specific=0 writes 8'h20.
- Back-pressure: hold vector_ready=0 for 10 cycles while INT re-asserts.
  - Only one INTA cycle occurs; vector stays stable; a second INTA occurs only after the handshake and the EOI.
- Reset mid-operation: assert reset during the ICW2 strobe and during ACK2.
  - All strobes go high the same cycle; init_done=0 and vector_valid=0.
  - A new start reruns the full init from ICW1.
